// File: rtl/atm_session_sequencer_if.sv
// Datapath handshake between the ATM session sequencer (master) and the
// account/balance datapath (slave). One operation is in flight at a time:
// dp_req stays high with dp_op/dp_amount stable until dp_ack is seen.
interface atm_session_sequencer_if #(
  parameter int AMT_W = 32
);
  logic             dp_req;
  logic [1:0]       dp_op;
  logic [AMT_W-1:0] dp_amount;
  logic             dp_ack;
  logic             dp_ok;

  modport master (output dp_req, dp_op, dp_amount, input dp_ack, dp_ok);
  modport slave  (input dp_req, dp_op, dp_amount, output dp_ack, dp_ok);
endinterface

// File: rtl/atm_session_sequencer.sv
// ATM card session sequencer: language, PIN with attempt limit, menu,
// datapath operation over req/ack, eject or retain.
// Optional feature macro: ATM_TIMEOUT_EN enables the inactivity timer
// (forced eject after TIMEOUT_CYCLES idle cycles in LANG/PIN/MENU/RESULT).
//
// state  | meaning
// IDLE   | no card; clears tries, correctPassword, lang_sel
// LANG   | waiting for language choice
// PIN    | waiting for PIN entry, counting failures
// MENU   | waiting for operation choice
// EXEC   | dp_req held until dp_ack; aborts deferred
// RESULT | waiting for "another operation?" answer
// EJECT  | cardEject until card removed
// RETAIN | cardRetained until slot reads empty
module atm_session_sequencer #(
  parameter int MAX_PIN_TRIES  = 3,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int AMT_W          = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cardIn,
  input  logic                           ejectCard,
  input  logic                           langValid,
  input  logic                           Language,
  input  logic                           pinValid,
  input  logic                           pinMatch,
  input  logic                           opValid,
  input  logic [1:0]                     opCode,
  input  logic [AMT_W-1:0]               amount,
  input  logic                           anotherValid,
  input  logic                           Another_Operation,
  atm_session_sequencer_if.master        dp,
  output logic                           lang_sel,
  output logic                           correctPassword,
  output logic                           Balance_Shown,
  output logic                           Deposited_Successfully,
  output logic                           Withdrawed_Successfully,
  output logic                           opFailed,
  output logic                           ATM_Usage_Finished,
  output logic                           cardEject,
  output logic                           cardRetained
);

  typedef enum logic [2:0] {IDLE, LANG, PIN, MENU, EXEC, RESULT, EJECT, RETAIN} state_t;

  state_t           state, state_nxt;
  logic [1:0]       tries, tries_nxt, tries_inc;
  logic             lang_nxt, cp_nxt;
  logic             req_q, req_nxt;
  logic [1:0]       op_q, op_nxt;
  logic [AMT_W-1:0] amt_q, amt_nxt;
  logic             bal_nxt, dep_nxt, wdr_nxt, fail_nxt, fin_nxt, ej_nxt, ret_nxt;
  logic             wait_st, timeout, abort;

  assign wait_st = (state == LANG) || (state == PIN) || (state == MENU) || (state == RESULT);
  // Card removal and cancel outrank the timer, which outranks data pulses.
  assign abort   = wait_st && (!cardIn || ejectCard || timeout);

`ifdef ATM_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TMR_W-1:0] timer;
  logic             data_acc, nxt_wait;

  assign timeout  = wait_st && (timer == '0);
  assign data_acc = wait_st && !abort &&
                    ((state == LANG   && langValid) || (state == PIN    && pinValid) ||
                     (state == MENU   && opValid)   || (state == RESULT && anotherValid));
  assign nxt_wait = (state_nxt == LANG) || (state_nxt == PIN) ||
                    (state_nxt == MENU) || (state_nxt == RESULT);

  // Inactivity down-counter: reload on entry or accepted pulse, expire at 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      timer <= '0;
    else if (!nxt_wait)
      timer <= '0;
    else if (state_nxt != state || data_acc)
      timer <= TMR_W'(TIMEOUT_CYCLES - 1);
    else if (timer != '0)
      timer <= timer - 1'b1;
  end
`else
  // No inactivity timer: sessions wait indefinitely (TIMEOUT_CYCLES is >= 2, so this is 0).
  assign timeout = (TIMEOUT_CYCLES == 0);
`endif

  // Next-state and next-output logic; all outputs are registered below.
  always_comb begin
    state_nxt = state;
    tries_inc = (tries == 2'd3) ? tries : tries + 2'd1;
    tries_nxt = tries;
    lang_nxt  = lang_sel;
    cp_nxt    = correctPassword;
    op_nxt    = op_q;
    amt_nxt   = amt_q;
    bal_nxt   = 1'b0;
    dep_nxt   = 1'b0;
    wdr_nxt   = 1'b0;
    fail_nxt  = 1'b0;
    if (abort) begin
      state_nxt = EJECT;
    end else begin
      case (state)
        IDLE: begin
          tries_nxt = 2'd0;
          lang_nxt  = 1'b0;
          cp_nxt    = 1'b0;
          if (cardIn) state_nxt = LANG;
        end
        LANG: if (langValid) begin
          lang_nxt  = Language;
          state_nxt = PIN;
        end
        PIN: if (pinValid) begin
          if (pinMatch) begin
            cp_nxt    = 1'b1;
            state_nxt = MENU;
          end else begin
            tries_nxt = tries_inc;
            if (tries_inc >= 2'(MAX_PIN_TRIES)) state_nxt = RETAIN;
          end
        end
        MENU: if (opValid) begin
          if (opCode == 2'b00) begin
            state_nxt = EJECT;
          end else begin
            op_nxt    = opCode;
            amt_nxt   = amount;
            state_nxt = EXEC;
          end
        end
        EXEC: if (dp.dp_ack) begin
          state_nxt = RESULT;
          if (dp.dp_ok) begin
            bal_nxt = (op_q == 2'b01);
            dep_nxt = (op_q == 2'b10);
            wdr_nxt = (op_q == 2'b11);
          end else begin
            fail_nxt = 1'b1;
          end
        end
        RESULT: if (anotherValid) state_nxt = Another_Operation ? MENU : EJECT;
        EJECT, RETAIN: if (!cardIn) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
    req_nxt = (state_nxt == EXEC);
    ej_nxt  = (state_nxt == EJECT);
    ret_nxt = (state_nxt == RETAIN);
    fin_nxt = (state_nxt != state) && (state_nxt == EJECT || state_nxt == RETAIN);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                   <= IDLE;
      tries                   <= 2'd0;
      lang_sel                <= 1'b0;
      correctPassword         <= 1'b0;
      req_q                   <= 1'b0;
      op_q                    <= 2'b00;
      amt_q                   <= '0;
      Balance_Shown           <= 1'b0;
      Deposited_Successfully  <= 1'b0;
      Withdrawed_Successfully <= 1'b0;
      opFailed                <= 1'b0;
      ATM_Usage_Finished      <= 1'b0;
      cardEject               <= 1'b0;
      cardRetained            <= 1'b0;
    end else begin
      state                   <= state_nxt;
      tries                   <= tries_nxt;
      lang_sel                <= lang_nxt;
      correctPassword         <= cp_nxt;
      req_q                   <= req_nxt;
      op_q                    <= op_nxt;
      amt_q                   <= amt_nxt;
      Balance_Shown           <= bal_nxt;
      Deposited_Successfully  <= dep_nxt;
      Withdrawed_Successfully <= wdr_nxt;
      opFailed                <= fail_nxt;
      ATM_Usage_Finished      <= fin_nxt;
      cardEject               <= ej_nxt;
      cardRetained            <= ret_nxt;
    end
  end

  assign dp.dp_req    = req_q;
  assign dp.dp_op     = op_q;
  assign dp.dp_amount = amt_q;

endmodule

// File: tb/tb_atm_session_sequencer.sv
// Directed bench for atm_session_sequencer: full sessions, PIN retention,
// refused deposit, card pull during a transaction, timeout and async reset.
module tb_atm_session_sequencer;
  localparam int AMT_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             cardIn, ejectCard, langValid, Language, pinValid, pinMatch;
  logic             opValid, anotherValid, Another_Operation;
  logic [1:0]       opCode;
  logic [AMT_W-1:0] amount;
  logic             lang_sel, correctPassword, Balance_Shown, Deposited_Successfully;
  logic             Withdrawed_Successfully, opFailed, ATM_Usage_Finished;
  logic             cardEject, cardRetained;

  int n_tests = 0;
  int n_fail  = 0;
  int req_cycles, wd_pulses, n;

  atm_session_sequencer_if #(.AMT_W(AMT_W)) dp_bus ();

  atm_session_sequencer #(
    .MAX_PIN_TRIES (3),
    .TIMEOUT_CYCLES(8),
    .AMT_W         (AMT_W)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .cardIn                 (cardIn),
    .ejectCard              (ejectCard),
    .langValid              (langValid),
    .Language               (Language),
    .pinValid               (pinValid),
    .pinMatch               (pinMatch),
    .opValid                (opValid),
    .opCode                 (opCode),
    .amount                 (amount),
    .anotherValid           (anotherValid),
    .Another_Operation      (Another_Operation),
    .dp                     (dp_bus),
    .lang_sel               (lang_sel),
    .correctPassword        (correctPassword),
    .Balance_Shown          (Balance_Shown),
    .Deposited_Successfully (Deposited_Successfully),
    .Withdrawed_Successfully(Withdrawed_Successfully),
    .opFailed               (opFailed),
    .ATM_Usage_Finished     (ATM_Usage_Finished),
    .cardEject              (cardEject),
    .cardRetained           (cardRetained)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_session(input logic lang);
    cardIn = 1'b1;
    step();
    Language  = lang;
    langValid = 1'b1;
    step();
    langValid = 1'b0;
  endtask

  task automatic to_menu();
    pinMatch = 1'b1;
    pinValid = 1'b1;
    step();
    pinValid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; cardIn = 1'b0; ejectCard = 1'b0; langValid = 1'b0; Language = 1'b0;
    pinValid = 1'b0; pinMatch = 1'b0; opValid = 1'b0; opCode = 2'b00; amount = '0;
    anotherValid = 1'b0; Another_Operation = 1'b0;
    dp_bus.dp_ack = 1'b0; dp_bus.dp_ok = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dp_req", dp_bus.dp_req, 0);
    check("rst_cardEject", cardEject, 0);
    check("rst_cardRetained", cardRetained, 0);
    check("rst_correctPassword", correctPassword, 0);
    check("rst_finish", ATM_Usage_Finished, 0);
    reset = 1'b1;
    step();

    // full withdraw session
    start_session(1'b1);
    check("wd_lang_sel", lang_sel, 1);
    to_menu();
    check("wd_correctPassword", correctPassword, 1);
    opCode = 2'b11; amount = 32'h40; opValid = 1'b1;
    step();
    opValid = 1'b0; amount = 32'h99;
    check("wd_req_rise", dp_bus.dp_req, 1);
    check("wd_dp_op", dp_bus.dp_op, 2'b11);
    req_cycles = 0; wd_pulses = 0;
    for (int i = 0; i < 3; i++) begin
      if (dp_bus.dp_req) req_cycles++;
      check("wd_amount_stable", dp_bus.dp_amount, 32'h40);
      if (i == 2) begin dp_bus.dp_ack = 1'b1; dp_bus.dp_ok = 1'b1; end
      step();
      if (Withdrawed_Successfully) wd_pulses++;
    end
    dp_bus.dp_ack = 1'b0;
    check("wd_req_cycles", req_cycles, 3);
    check("wd_pulse_at_result", Withdrawed_Successfully, 1);
    check("wd_req_drop", dp_bus.dp_req, 0);
    check("wd_no_dep_pulse", Deposited_Successfully, 0);
    step();
    if (Withdrawed_Successfully) wd_pulses++;
    check("wd_pulse_count", wd_pulses, 1);
    anotherValid = 1'b1; Another_Operation = 1'b0;
    step();
    anotherValid = 1'b0;
    check("wd_finish_pulse", ATM_Usage_Finished, 1);
    check("wd_eject_on", cardEject, 1);
    step();
    check("wd_finish_one_cycle", ATM_Usage_Finished, 0);
    check("wd_eject_held", cardEject, 1);
    cardIn = 1'b0;
    step();
    check("wd_eject_off", cardEject, 0);
    step();
    check("idle_clears_cp", correctPassword, 0);
    check("idle_clears_lang", lang_sel, 0);

    // three wrong PINs retain the card
    start_session(1'b0);
    pinMatch = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      pinValid = 1'b1;
      step();
      pinValid = 1'b0;
      check("pin_no_req", dp_bus.dp_req, 0);
      check("pin_retain_state", cardRetained, (i == 3));
      check("pin_finish", ATM_Usage_Finished, (i == 3));
    end
    step();
    check("retain_finish_one_cycle", ATM_Usage_Finished, 0);
    check("retain_held", cardRetained, 1);
    cardIn = 1'b0;
    step();
    check("retain_released", cardRetained, 0);

    // tries restart each session; stray pulses in MENU ignored
    start_session(1'b0);
    pinMatch = 1'b0;
    repeat (2) begin pinValid = 1'b1; step(); pinValid = 1'b0; end
    check("tries_fresh_no_retain", cardRetained, 0);
    to_menu();
    check("tries_fresh_menu", correctPassword, 1);
    Language = 1'b1; langValid = 1'b1; pinMatch = 1'b0; pinValid = 1'b1;
    step();
    langValid = 1'b0; pinValid = 1'b0;
    check("menu_ignores_lang", lang_sel, 0);
    check("menu_ignores_pin", cardRetained, 0);

    // refused deposit, then another operation
    opCode = 2'b10; amount = 32'h25; opValid = 1'b1;
    step();
    opValid = 1'b0;
    check("dep_req", dp_bus.dp_req, 1);
    check("dep_op", dp_bus.dp_op, 2'b10);
    dp_bus.dp_ack = 1'b1; dp_bus.dp_ok = 1'b0;
    step();
    dp_bus.dp_ack = 1'b0;
    check("dep_opFailed", opFailed, 1);
    check("dep_no_success", Deposited_Successfully, 0);
    check("dep_req_drop", dp_bus.dp_req, 0);
    step();
    check("dep_opFailed_one_cycle", opFailed, 0);
    anotherValid = 1'b1; Another_Operation = 1'b1;
    step();
    anotherValid = 1'b0;
    check("dep_back_menu_cp", correctPassword, 1);
    check("dep_back_menu_no_eject", cardEject, 0);

    // balance with card pulled mid-transaction
    opCode = 2'b01; opValid = 1'b1;
    step();
    opValid = 1'b0;
    check("bal_req", dp_bus.dp_req, 1);
    check("bal_op", dp_bus.dp_op, 2'b01);
    cardIn = 1'b0;
    step();
    check("bal_req_held", dp_bus.dp_req, 1);
    check("bal_no_eject_in_exec", cardEject, 0);
    dp_bus.dp_ack = 1'b1; dp_bus.dp_ok = 1'b1;
    step();
    dp_bus.dp_ack = 1'b0;
    check("bal_pulse", Balance_Shown, 1);
    check("bal_req_drop", dp_bus.dp_req, 0);
    check("bal_not_yet_eject", cardEject, 0);
    step();
    check("bal_eject", cardEject, 1);
    check("bal_finish", ATM_Usage_Finished, 1);
    step();
    check("bal_idle", cardEject, 0);

    // cancel request in PIN
    start_session(1'b1);
    ejectCard = 1'b1;
    step();
    ejectCard = 1'b0;
    check("cancel_eject", cardEject, 1);
    check("cancel_finish", ATM_Usage_Finished, 1);
    cardIn = 1'b0;
    step();
    check("cancel_idle", cardEject, 0);

    // exit opcode from MENU
    start_session(1'b0);
    to_menu();
    opCode = 2'b00; opValid = 1'b1;
    step();
    opValid = 1'b0;
    check("exit_no_req", dp_bus.dp_req, 0);
    check("exit_eject", cardEject, 1);
    cardIn = 1'b0;
    step();

`ifdef ATM_TIMEOUT_EN
    start_session(1'b0);
    to_menu();
    n = 0;
    while (!cardEject && n < 20) begin step(); n++; end
    check("tmo_menu_cycles", n, 8);
    cardIn = 1'b0;
    step();
    start_session(1'b0);
    repeat (4) step();
    pinMatch = 1'b0; pinValid = 1'b1;
    step();
    pinValid = 1'b0;
    n = 0;
    while (!cardEject && n < 20) begin step(); n++; end
    check("tmo_restart_cycles", n, 8);
    cardIn = 1'b0;
    step();
`else
    start_session(1'b0);
    to_menu();
    repeat (30) step();
    check("no_timeout_wait", cardEject, 0);
    cardIn = 1'b0;
    step();
    check("no_timeout_pull_eject", cardEject, 1);
    step();
    check("no_timeout_idle", cardEject, 0);
`endif

    // async reset in EXEC
    start_session(1'b1);
    to_menu();
    opCode = 2'b11; amount = 32'h5; opValid = 1'b1;
    step();
    opValid = 1'b0;
    check("arst_req_before", dp_bus.dp_req, 1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_req_drop", dp_bus.dp_req, 0);
    check("arst_cp_clear", correctPassword, 0);
    check("arst_lang_clear", lang_sel, 0);
    check("arst_no_finish", ATM_Usage_Finished, 0);
    @(posedge clk);
    #1;
    check("arst_no_finish_later", ATM_Usage_Finished, 0);
    reset = 1'b1;
    step();
    check("arst_restart_no_req", dp_bus.dp_req, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/atm_session_sequencer.md
# atm_session_sequencer

Session controller for the ATM. It sequences one card session from insertion to ejection: language selection, PIN entry with an attempt limit, menu, and operation execution. Operations are issued to the account/balance datapath through a req/ack handshake. It drives the user-visible status flags, replacing ad-hoc sequencing inside the ATM top level.

## Interface
- MAX_PIN_TRIES, 3: failed PIN entries before the card is retained (1..3).
- TIMEOUT_CYCLES, 1000: inactivity cycles before forced eject (≥2).
- AMT_W, 32: amount width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cardIn  in  1  level, card present in slot.
- ejectCard  in  1  pulse, user cancel/eject request.
- langValid  in  1  pulse, language choice valid.
- Language  in  1  language choice, sampled with langValid.
- pinValid  in  1  pulse, PIN entry complete.
- pinMatch  in  1  PIN checker result, sampled with pinValid.
- opValid  in  1  pulse, menu choice valid.
- opCode  in  2  00 exit, 01 view balance, 10 deposit, 11 withdraw.
- amount  in  AMT_W  operation amount, sampled with opValid.
- anotherValid  in  1  pulse, answer to "another operation?".
- Another_Operation  in  1  answer, sampled with anotherValid.
- dp_req  out  1  datapath request.
- dp_op  out  2  latched opCode.
- dp_amount  out  AMT_W  latched amount.
- dp_ack  in  1  datapath done.
- dp_ok  in  1  datapath success (0 = insufficient funds/refused), sampled with dp_ack.
- lang_sel  out  1  latched language.
- correctPassword  out  1  level, PIN accepted in this session.
- Balance_Shown, Deposited_Successfully, Withdrawed_Successfully  out  1 each  one-cycle success pulses.
- opFailed  out  1  one-cycle pulse on dp_ok=0.
- ATM_Usage_Finished  out  1  one-cycle pulse at session end.
- cardEject  out  1  level, eject mechanism active.
- cardRetained  out  1  level, card swallowed.

## Operation
- States: IDLE, LANG, PIN, MENU, EXEC, RESULT, EJECT, RETAIN.
- IDLE: cardIn=1 → LANG. Clears the tries counter, correctPassword and lang_sel.
- LANG: langValid latches Language into lang_sel → PIN.
- PIN, pinValid with pinMatch=1 → MENU; correctPassword=1.
- PIN, pinValid with pinMatch=0: tries+1. If tries reaches MAX_PIN_TRIES → RETAIN, else stay in PIN.
- MENU: opValid with opCode 00 → EJECT. Otherwise latch dp_op/dp_amount → EXEC.
- EXEC: dp_req=1 until dp_ack is sampled, then → RESULT. On that edge pulse the matching success flag if dp_ok=1, else opFailed.
- RESULT: anotherValid with Another_Operation=1 → MENU; with 0 → EJECT.
- EJECT: ATM_Usage_Finished pulses on entry; cardEject=1 until cardIn=0 → IDLE.
- RETAIN: ATM_Usage_Finished pulses on entry; cardRetained=1 until cardIn=0 → IDLE.
- Priority in LANG/PIN/MENU/RESULT, highest first: cardIn=0 (→ EJECT, completes immediately), ejectCard (→ EJECT), timeout (→ EJECT), data pulses.
- EXEC ignores cardIn, ejectCard and timeout. The transaction always completes; any pending abort is honoured in RESULT.
- Data pulses arriving in the wrong state are ignored.

## Timing
- All outputs are registered.
- Reset values: state IDLE, all outputs 0, tries 0, timer 0.
- Reset asserted mid-session takes effect immediately: dp_req drops asynchronously and no finish pulse is produced.
- The opValid edge and the first dp_req=1 cycle are the same edge; latency is 1 cycle.
- dp_op/dp_amount are stable while dp_req=1.
- dp_ack in the same cycle dp_req rises is accepted. Minimum EXEC duration is 1 cycle.
- Success/failure pulse is coincident with the first RESULT cycle.
- Timer:
  - Reloads to TIMEOUT_CYCLES-1 on entering LANG/PIN/MENU/RESULT and on any accepted data pulse.
  - Decrements every cycle in those states.
  - Expiry is the edge where the count is 0; EJECT follows on the next cycle.
- Tries counter saturates and never wraps. It resets only in IDLE, so a wrong PIN followed by another operation does not carry over across sessions.

## Configuration
- ATM_TIMEOUT_EN defined: inactivity timer present as specified.
- ATM_TIMEOUT_EN undefined: no timer logic; TIMEOUT_CYCLES is unused and sessions wait indefinitely for input.

## Test plan
- Full withdraw session:
  - Stimulus: cardIn=1, langValid (Language=1), pinValid/pinMatch=1, opValid op=11 amount=0x40, dp_ack/dp_ok=1 after 3 cycles, anotherValid=0, cardIn=0.
  - Response: dp_req high 3 cycles with dp_amount=0x40; one Withdrawed_Successfully pulse; ATM_Usage_Finished pulse; cardEject until card removed; back in IDLE.
- Three wrong PINs (MAX_PIN_TRIES=3): third pinValid → cardRetained=1 plus ATM_Usage_Finished pulse; no dp_req ever.
- Deposit refused: op=10, dp_ack with dp_ok=0 → opFailed pulse, no Deposited_Successfully; Another_Operation=1 → back in MENU with correctPassword still 1.
- Card pulled during EXEC: cardIn=0 while dp_req=1 → dp_req held until dp_ack; balance pulse emitted; EJECT on the next cycle.
- Timeout (TIMEOUT_CYCLES=8, ATM_TIMEOUT_EN): idle in MENU → EJECT after 8 cycles. A pulse at cycle 5 restarts the count.
- Async reset mid-EXEC → dp_req=0 and IDLE without a clock edge.
